// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared types/constants for the PIC10 instruction ctrl  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_SLEEP = 2'd3
  } state_t;

  localparam logic [1:0] PCSEL_GOTO  = 2'b00;
  localparam logic [1:0] PCSEL_CALL  = 2'b01;
  localparam logic [1:0] PCSEL_STACK = 2'b10;
  localparam logic [1:0] PCSEL_ALU   = 2'b11;

  localparam logic [11:0] NOP = 12'h000;

  localparam logic [11:0] GOTO_MASK   = 12'hE00;
  localparam logic [11:0] GOTO_VAL    = 12'hA00;
  localparam logic [11:0] CALL_MASK   = 12'hF00;
  localparam logic [11:0] CALL_VAL    = 12'h900;
  localparam logic [11:0] RETLW_MASK  = 12'hF00;
  localparam logic [11:0] RETLW_VAL   = 12'h800;
  localparam logic [11:0] SLEEP_MASK  = 12'hFFF;
  localparam logic [11:0] SLEEP_VAL   = 12'h003;
  localparam logic [11:0] BTFSC_MASK  = 12'hF00;
  localparam logic [11:0] BTFSC_VAL   = 12'h600;
  localparam logic [11:0] BTFSS_MASK  = 12'hF00;
  localparam logic [11:0] BTFSS_VAL   = 12'h700;
  localparam logic [11:0] DECFSZ_MASK = 12'hFC0;
  localparam logic [11:0] DECFSZ_VAL  = 12'h2C0;
  localparam logic [11:0] INCFSZ_MASK = 12'hFC0;
  localparam logic [11:0] INCFSZ_VAL  = 12'h3C0;

  function automatic logic op_match(input logic [11:0] ir,
                                    input logic [11:0] mask,
                                    input logic [11:0] value);
    return (ir & mask) == value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_instruction_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_instruction_decode : IR opcode classification (combinational)     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu_instruction_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [11:0] instruction_reg,
  output logic        is_goto,
  output logic        is_call,
  output logic        is_retlw,
  output logic        is_sleep,
  output logic        is_skip
);

  assign is_goto  = op_match(instruction_reg, GOTO_MASK,  GOTO_VAL);
  assign is_call  = op_match(instruction_reg, CALL_MASK,  CALL_VAL);
  assign is_retlw = op_match(instruction_reg, RETLW_MASK, RETLW_VAL);
  assign is_sleep = op_match(instruction_reg, SLEEP_MASK, SLEEP_VAL);

  // BTFSC, BTFSS, DECFSZ, INCFSZ
  assign is_skip  = op_match(instruction_reg, BTFSC_MASK,  BTFSC_VAL)
                  | op_match(instruction_reg, BTFSS_MASK,  BTFSS_VAL)
                  | op_match(instruction_reg, DECFSZ_MASK, DECFSZ_VAL)
                  | op_match(instruction_reg, INCFSZ_MASK, INCFSZ_VAL);

endmodule
`default_nettype wire

// File: rtl/cpu_instruction_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_instruction_control : PC/IR/stack sequencer, 2-stage fetch/exec   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module cpu_instruction_control
  import cpu_ctrl_pkg::*;
#(
  parameter int          STACK_DEPTH = 2,
  parameter logic [4:0]  PCL_ADDR    = 5'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] instruction_reg,
  input  logic        skip_condition,
  input  logic        pcl_write,
  input  logic        halt,
  input  logic        wake,
  output logic        nop_insert,
  output logic        load_instruction,
  output logic [1:0]  pc_mux_select,
  output logic        load_pc,
  output logic        inc_pc,
  output logic        load_stack,
  output logic        inc_stack,
  output logic        dec_stack,
  output logic        exec_enable,
  output logic        sleeping,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  localparam int c_depth_w = $clog2(STACK_DEPTH + 1);
  localparam logic [c_depth_w-1:0] c_depth_max = c_depth_w'(STACK_DEPTH);

  // PCL_ADDR is informational only: pcl_write arrives already decoded.
  if (PCL_ADDR == 5'h00) begin : g_pcl_addr_info
  end

  state_t               r_state, w_next_state;
  logic [c_depth_w-1:0] r_depth;
  logic                 r_overflow, r_underflow;
  logic                 w_is_goto, w_is_call, w_is_retlw, w_is_sleep, w_is_skip;

  cpu_instruction_decode u_decode (
    .instruction_reg (instruction_reg),
    .is_goto         (w_is_goto),
    .is_call         (w_is_call),
    .is_retlw        (w_is_retlw),
    .is_sleep        (w_is_sleep),
    .is_skip         (w_is_skip)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_RESET;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state     = r_state;
    nop_insert       = 1'b0;
    load_instruction = 1'b0;
    pc_mux_select    = PCSEL_GOTO;
    load_pc          = 1'b0;
    inc_pc           = 1'b0;
    load_stack       = 1'b0;
    inc_stack        = 1'b0;
    dec_stack        = 1'b0;
    exec_enable      = 1'b0;
    sleeping         = 1'b0;
    if (!rst) begin
      nop_insert       = 1'b1;
      load_instruction = 1'b1;
      w_next_state     = S_RESET;
    end else begin
      case (r_state)
        S_RESET: begin
          nop_insert       = 1'b1;
          load_instruction = 1'b1;
          w_next_state     = S_RUN;
        end
        S_RUN: begin
          if (halt) begin
            w_next_state = S_HALT;
          end else begin
            exec_enable      = 1'b1;
            load_instruction = 1'b1;
            inc_pc           = 1'b1;
            if (w_is_sleep) begin
              nop_insert   = 1'b1;
              w_next_state = S_SLEEP;
            end else if (w_is_goto) begin
              load_pc    = 1'b1;
              inc_pc     = 1'b0;
              nop_insert = 1'b1;
            end else if (w_is_call) begin
              // PC already points past the CALL, so it is the return address
              load_stack    = 1'b1;
              inc_stack     = 1'b1;
              load_pc       = 1'b1;
              pc_mux_select = PCSEL_CALL;
              inc_pc        = 1'b0;
              nop_insert    = 1'b1;
            end else if (w_is_retlw) begin
              dec_stack     = 1'b1;
              load_pc       = 1'b1;
              pc_mux_select = PCSEL_STACK;
              inc_pc        = 1'b0;
              nop_insert    = 1'b1;
            end else if (pcl_write) begin
              load_pc       = 1'b1;
              pc_mux_select = PCSEL_ALU;
              inc_pc        = 1'b0;
              nop_insert    = 1'b1;
            end else if (w_is_skip && skip_condition) begin
              nop_insert = 1'b1;
            end
          end
        end
        S_HALT: begin
          if (!halt) w_next_state = S_RUN;
        end
        S_SLEEP: begin
          sleeping = 1'b1;
          if (wake) w_next_state = S_RUN;
        end
        default: w_next_state = S_RESET;
      endcase
    end
  end

  // Strobes are never suppressed at the limits; only the depth saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (inc_stack) begin
        if (r_depth == c_depth_max) r_overflow <= 1'b1;
        else                        r_depth    <= r_depth + 1'b1;
      end
      if (dec_stack) begin
        if (r_depth == '0) r_underflow <= 1'b1;
        else               r_depth     <= r_depth - 1'b1;
      end
    end
  end

  assign stack_overflow  = r_overflow;
  assign stack_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cpu_instruction_control.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cpu_instruction_control : directed self-checking bench             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_cpu_instruction_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instruction_reg;
  logic        skip_condition, pcl_write, halt, wake;
  logic        nop_insert, load_instruction, load_pc, inc_pc;
  logic [1:0]  pc_mux_select;
  logic        load_stack, inc_stack, dec_stack, exec_enable, sleeping;
  logic        stack_overflow, stack_underflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_instruction_control #(.STACK_DEPTH(2), .PCL_ADDR(5'h02)) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_reg  (instruction_reg),
    .skip_condition   (skip_condition),
    .pcl_write        (pcl_write),
    .halt             (halt),
    .wake             (wake),
    .nop_insert       (nop_insert),
    .load_instruction (load_instruction),
    .pc_mux_select    (pc_mux_select),
    .load_pc          (load_pc),
    .inc_pc           (inc_pc),
    .load_stack       (load_stack),
    .inc_stack        (inc_stack),
    .dec_stack        (dec_stack),
    .exec_enable      (exec_enable),
    .sleeping         (sleeping),
    .stack_overflow   (stack_overflow),
    .stack_underflow  (stack_underflow)
  );

  // Vector order: nop ld sel[1:0] lpc ipc lst ist dst ex sl ov un
  function automatic logic [12:0] e(input logic nop, input logic ld, input logic [1:0] sel,
                                    input logic lpc, input logic ipc, input logic lst,
                                    input logic ist, input logic dst, input logic ex,
                                    input logic sl, input logic ov, input logic un);
    return {nop, ld, sel, lpc, ipc, lst, ist, dst, ex, sl, ov, un};
  endfunction

  task automatic check(input string tag, input logic [12:0] expected);
    logic [12:0] observed;
    observed = {nop_insert, load_instruction, pc_mux_select, load_pc, inc_pc,
                load_stack, inc_stack, dec_stack, exec_enable, sleeping,
                stack_overflow, stack_underflow};
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Inputs change just after a negedge; outputs are checked 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [11:0] ir);
    instruction_reg = ir;
    #1;
  endtask

  initial begin
    rst = 1'b0; instruction_reg = 12'hA05;
    skip_condition = 1'b0; pcl_write = 1'b0; halt = 1'b0; wake = 1'b0;

    // 1. reset held two cycles, then one S_RESET cycle, then run
    tick(); #1;
    check("reset_c1",   e(1,1,2'b00,0,0,0,0,0,0,0,0,0));
    tick(); #1;
    check("reset_c2",   e(1,1,2'b00,0,0,0,0,0,0,0,0,0));
    rst = 1'b1; drive(12'h000);
    check("s_reset",    e(1,1,2'b00,0,0,0,0,0,0,0,0,0));
    tick(); drive(12'h000);
    check("first_run",  e(0,1,2'b00,0,1,0,0,0,1,0,0,0));

    // 2. GOTO for exactly one cycle
    tick(); drive(12'hA35);
    check("goto",       e(1,1,2'b00,1,0,0,0,0,1,0,0,0));
    tick(); drive(12'h000);
    check("after_goto", e(0,1,2'b00,0,1,0,0,0,1,0,0,0));

    // 3. CALL then RETLW: depth 0->1->0, no flags
    tick(); drive(12'h912);
    check("call",       e(1,1,2'b01,1,0,1,1,0,1,0,0,0));
    tick(); drive(12'h8FF);
    check("retlw",      e(1,1,2'b10,1,0,0,0,1,1,0,0,0));
    tick(); drive(12'h000);
    check("no_flags",   e(0,1,2'b00,0,1,0,0,0,1,0,0,0));

    // 4a. three CALLs: overflow on the third, depth saturates at 2
    tick(); drive(12'h912);
    check("call_d0",    e(1,1,2'b01,1,0,1,1,0,1,0,0,0));
    tick(); drive(12'h934);
    check("call_d1",    e(1,1,2'b01,1,0,1,1,0,1,0,0,0));
    tick(); drive(12'h956);
    check("call_full",  e(1,1,2'b01,1,0,1,1,0,1,0,0,0));
    tick(); drive(12'h000);
    check("overflow",   e(0,1,2'b00,0,1,0,0,0,1,0,1,0));
    // two pops empty a saturated stack, a third underflows
    tick(); drive(12'h801);
    check("pop_d2",     e(1,1,2'b10,1,0,0,0,1,1,0,1,0));
    tick(); drive(12'h802);
    check("pop_d1",     e(1,1,2'b10,1,0,0,0,1,1,0,1,0));
    tick(); drive(12'h000);
    check("depth_zero", e(0,1,2'b00,0,1,0,0,0,1,0,1,0));
    tick(); drive(12'h803);
    check("pop_d0",     e(1,1,2'b10,1,0,0,0,1,1,0,1,0));
    tick(); drive(12'h000);
    check("both_flags", e(0,1,2'b00,0,1,0,0,0,1,0,1,1));
    tick(); drive(12'h000);
    check("flags_hold", e(0,1,2'b00,0,1,0,0,0,1,0,1,1));

    // 4b. reset clears flags; RETLW straight from reset underflows
    rst = 1'b0; tick(); #1;
    check("rst_clear",  e(1,1,2'b00,0,0,0,0,0,0,0,0,0));
    rst = 1'b1; drive(12'h000);
    tick(); drive(12'h8FF);
    check("retlw_rst",  e(1,1,2'b10,1,0,0,0,1,1,0,0,0));
    tick(); drive(12'h000);
    check("underflow",  e(0,1,2'b00,0,1,0,0,0,1,0,0,1));
    rst = 1'b0; tick(); #1;
    rst = 1'b1; drive(12'h000);
    tick(); drive(12'h000);
    check("run_clean",  e(0,1,2'b00,0,1,0,0,0,1,0,0,0));

    // 5. skips and PCL writes
    skip_condition = 1'b1; drive(12'h603);
    check("btfsc_skip", e(1,1,2'b00,0,1,0,0,0,1,0,0,0));
    skip_condition = 1'b0; drive(12'h603);
    check("btfsc_noskp",e(0,1,2'b00,0,1,0,0,0,1,0,0,0));
    skip_condition = 1'b1; drive(12'h2C5);
    check("decfsz_skip",e(1,1,2'b00,0,1,0,0,0,1,0,0,0));
    drive(12'h3E1);
    check("incfsz_skip",e(1,1,2'b00,0,1,0,0,0,1,0,0,0));
    drive(12'h285);
    check("decf_noskip",e(0,1,2'b00,0,1,0,0,0,1,0,0,0));
    skip_condition = 1'b0;
    pcl_write = 1'b1; drive(12'h022);
    check("pcl_write",  e(1,1,2'b11,1,0,0,0,0,1,0,0,0));
    pcl_write = 1'b0; drive(12'h000);

    // 6a. halt on a GOTO: three idle cycles, then the GOTO executes
    tick(); halt = 1'b1; drive(12'hA35);
    check("halt_c1",    e(0,0,2'b00,0,0,0,0,0,0,0,0,0));
    tick(); #1;
    check("halt_c2",    e(0,0,2'b00,0,0,0,0,0,0,0,0,0));
    tick(); #1;
    check("halt_c3",    e(0,0,2'b00,0,0,0,0,0,0,0,0,0));
    halt = 1'b0; #1;
    check("halt_rel",   e(0,0,2'b00,0,0,0,0,0,0,0,0,0));
    tick(); #1;
    check("goto_resume",e(1,1,2'b00,1,0,0,0,0,1,0,0,0));

    // 6b. SLEEP, halt ignored while asleep, wake resumes fetch
    tick(); drive(12'h003);
    check("sleep_instr",e(1,1,2'b00,0,1,0,0,0,1,0,0,0));
    tick(); drive(12'h000);
    check("sleeping",   e(0,0,2'b00,0,0,0,0,0,0,1,0,0));
    halt = 1'b1; #1;
    tick(); #1;
    check("sleep_halt", e(0,0,2'b00,0,0,0,0,0,0,1,0,0));
    halt = 1'b0; wake = 1'b1; #1;
    check("wake_req",   e(0,0,2'b00,0,0,0,0,0,0,1,0,0));
    tick(); wake = 1'b0; drive(12'h000);
    check("woken",      e(0,1,2'b00,0,1,0,0,0,1,0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cpu_instruction_control.md
Name: cpu_instruction_control

Overview:
- Sequencer for the PC / instruction register / return-stack datapath of the PIC10-compatible CPU.
- Decodes the 12-bit word in the instruction register and produces every datapath control strobe: nop_insert, load_instruction, pc_mux_select, load_pc, inc_pc, load_stack, inc_stack, dec_stack.
- Implements a 2-stage overlapped fetch/execute. Taken branches and skips flush the prefetched word by loading a NOP into the IR.
- Also handles SLEEP/wake, external halt, and stack depth/overflow tracking.

Parameters:
STACK_DEPTH, 2, number of return-stack levels (PIC10 = 2)
PCL_ADDR, 5'h02, file address of PCL (informational; pcl_write is decoded upstream)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
instruction_reg  input  12  current IR contents
skip_condition  input  1  datapath result for skip instructions (BTFSC/BTFSS bit test, DECFSZ/INCFSZ zero), valid in execute cycle
pcl_write  input  1  current instruction writes alu_output to PCL
halt  input  1  debug freeze request
wake  input  1  wake from SLEEP (WDT/pin)
nop_insert  output  1  replace program_bus with NOP on IR load
load_instruction  output  1  IR load enable
pc_mux_select  output  2  00 GOTO k[8:0], 01 CALL {0,k[7:0]}, 10 stack, 11 ALU
load_pc  output  1  PC load from mux
inc_pc  output  1  PC increment
load_stack  output  1  write PC into stack
inc_stack  output  1  stack pointer increment
dec_stack  output  1  stack pointer decrement
exec_enable  output  1  gates W/file/status writes for the IR instruction
sleeping  output  1  core in SLEEP
stack_overflow  output  1  sticky: push at full depth
stack_underflow  output  1  sticky: pop at zero depth

Behaviour:
- Program ROM read is combinational from PC. program_bus is valid in the same cycle as PC.
- States: S_RESET, S_RUN, S_HALT, S_SLEEP. The state register is updated on clk rising edge.
- rst=0 (sampled at posedge):
  - State goes to S_RESET; depth goes to 0; both sticky flags clear.
  - All outputs 0 except nop_insert=1 and load_instruction=1, so the IR is filled with NOP.
- S_RESET, for exactly one cycle: IR←NOP, inc_pc=0. Next state S_RUN.
- S_RUN, one instruction per cycle, with exec_enable=1. Default strobes: load_instruction=1, inc_pc=1, nop_insert=0.
- S_RUN decode, first match wins:
  - halt=1: all strobes 0 and exec_enable=0; next state S_HALT. The instruction is not executed.
  - SLEEP (0x003): exec_enable=1, load_instruction=1 with nop_insert=1, inc_pc=1; next state S_SLEEP.
  - GOTO (101x_xxxx_xxxx): load_pc=1, sel=00, inc_pc=0, nop_insert=1.
  - CALL (1001_xxxx_xxxx): load_stack=1, inc_stack=1 (pushes PC, which is the return address), load_pc=1, sel=01, inc_pc=0, nop_insert=1.
  - RETLW (1000_xxxx_xxxx): dec_stack=1, load_pc=1, sel=10, inc_pc=0, nop_insert=1.
  - pcl_write=1: load_pc=1, sel=11, inc_pc=0, nop_insert=1.
  - Skip opcodes (0110, 0111, 0010_11, 0011_11) with skip_condition=1: nop_insert=1, with PC incrementing normally.
  - Otherwise: plain fetch.
- load_pc and inc_pc are never both 1. inc_stack and dec_stack are never both 1.
- Stack depth counter, range 0..STACK_DEPTH:
  - Push at depth=STACK_DEPTH: strobes are still issued, depth saturates, and stack_overflow is set.
  - Pop at depth=0: strobes are still issued, and stack_underflow is set.
  - Both flags stay set until reset.
- S_HALT: all strobes 0, exec_enable=0. halt=0 → S_RUN, where the held IR instruction then executes.
- S_SLEEP: sleeping=1, all strobes 0, exec_enable=0. wake=1 → S_RUN; the next IR word is the one already fetched at PC. halt is ignored in S_SLEEP.
- Reset in any state overrides all other inputs in that cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - pc_mux_select encodings (PCSEL_GOTO/CALL/STACK/ALU);
  - opcode masks and match values for GOTO, CALL, RETLW, SLEEP, and the skip set;
  - NOP constant 12'h000.
- One sub-module: cpu_instruction_decode, purely combinational, mapping instruction_reg to is_goto, is_call, is_retlw, is_sleep, is_skip.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with IR=12'hA05 → nop_insert=1, load_instruction=1, other strobes 0. Release: one S_RESET cycle, then inc_pc=1 on the following cycle.
2. GOTO: IR=12'hA35 in S_RUN → load_pc=1, sel=00, nop_insert=1, inc_pc=0, exec_enable=1 for exactly one cycle.
3. CALL then RETLW: IR=12'h912 → load_stack=inc_stack=load_pc=1, sel=01, depth 0→1. Then IR=12'h8FF → dec_stack=1, sel=10, depth 1→0, no flags set.
4. Stack limits: three CALLs with no return → third sets stack_overflow=1 and depth stays 2. From reset, a RETLW sets stack_underflow=1. Both flags hold until rst=0.
5. Skips: IR=12'h603 with skip_condition=1 → nop_insert=1, inc_pc=1, load_pc=0. Same with skip_condition=0 → nop_insert=0. pcl_write=1 → sel=11, load_pc=1.
6. Halt and sleep: halt=1 on a GOTO → 0 strobes for 3 cycles; on halt=0 the GOTO executes. IR=12'h003 → sleeping=1 from next cycle; wake=1 → S_RUN and inc_pc=1 the cycle after.
